// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and grant encoding for the register-file write-back arbiter
package rf_pkg;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;
   typedef enum logic {G0 = 1'b0, G1 = 1'b1} grant_t;
endpackage

// File: rtl/rf_pending_tracker.sv
// rf_pending_tracker: per-register bitmap of accepted writes not yet committed
// Ports: clk, rst_n (sync active-low), set_en/set_addr mark a register,
// clr_en/clr_addr release it one cycle later, pending is the bitmap.
module rf_pending_tracker
   import rf_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   output logic [2**AW-1:0] pending
);
   localparam int N = 2**AW;
   logic [N-1:0] r_pend;
   logic [N-1:0] w_set;
   logic [N-1:0] w_clr;
   always_comb begin
      w_set = {{(N-1){1'b0}}, set_en} << set_addr;
      w_clr = {{(N-1){1'b0}}, clr_en} << clr_addr;
   end
   // set is OR-ed after the clear so a re-write of the same register wins
   always_ff @(posedge clk) begin
      if (!rst_n) r_pend <= '0;
      else        r_pend <= (r_pend & ~w_clr) | w_set;
   end
   // a reset cycle must already show an empty bitmap
   assign pending = rst_n ? r_pend : '0;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester arbiter feeding one register-file write port
// Ports: clk, rst_n (sync active-low); req0/req1 valid/addr/data in, ready out;
// hold blocks all grants; rf_wren/rf_waddr/rf_wdata registered write port;
// pending bitmap of in-flight writes.
// Config macro RF_WB_ROUND_ROBIN_EN: defined = round robin on contention,
// undefined = requester 0 always wins contention.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [AW-1:0]    req0_addr,
   input  logic [DW-1:0]    req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [AW-1:0]    req1_addr,
   input  logic [DW-1:0]    req1_data,
   output logic             req1_ready,
   input  logic             hold,
   output logic             rf_wren,
   output logic [AW-1:0]    rf_waddr,
   output logic [DW-1:0]    rf_wdata,
   output logic [2**AW-1:0] pending
);
`ifdef RF_WB_ROUND_ROBIN_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif
   grant_t        r_last;
   logic          r_wren;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic          w_ok;
   logic          w_pick1;
   logic          w_acc;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   // w_pick1 only matters on contention; last_grant is tracked in both builds
   always_comb begin
      w_ok       = rst_n & ~hold;
      w_pick1    = RR_EN & (r_last == G0);
      req0_ready = w_ok & req0_valid & ~(req1_valid & w_pick1);
      req1_ready = w_ok & req1_valid & ~(req0_valid & ~w_pick1);
      w_acc      = req0_ready | req1_ready;
      w_addr     = req1_ready ? req1_addr : req0_addr;
      w_data     = req1_ready ? req1_data : req0_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wren  <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_last  <= G1;
      end else begin
         r_wren <= w_acc;
         if (w_acc) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
            r_last  <= req1_ready ? G1 : G0;
         end
      end
   end
   // gating with rst_n drops a queued write the moment reset is asserted
   assign rf_wren  = r_wren & rst_n;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
   rf_pending_tracker #(.AW(AW)) u_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (w_acc),
      .set_addr(w_addr),
      .clr_en  (r_wren),
      .clr_addr(r_waddr),
      .pending (pending)
   );
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5, register address width.
REQ-002 SHALL have parameter DW, default 32, write data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a write pending.
REQ-006 SHALL have ports req0_addr / req1_addr  input  AW  destination register.
REQ-007 SHALL have ports req0_data / req1_data  input  DW  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  grant; transfer occurs when valid and ready are both high at a rising edge.
REQ-009 SHALL have port hold  input  1  suppresses all grants this cycle.
REQ-010 SHALL have ports rf_wren  output  1, rf_waddr  output  AW, rf_wdata  output  DW  driving the register file write port.
REQ-011 SHALL have port pending  output  2**AW  per-register flag set while an accepted write is not yet committed.

Function
REQ-012 SHALL compute req0_ready and req1_ready combinationally from valids, hold and arbitration state; at most one SHALL be high.
REQ-013 SHALL grant no requester while hold=1 or rst_n=0.
REQ-014 SHALL keep last_grant state (G0/G1); a grant to requester k SHALL set last_grant=Gk at the edge.
REQ-015 SHALL grant the sole valid requester immediately when only one is valid, independent of last_grant.
REQ-016 SHALL, when both are valid, grant per the configured policy (REQ-027/028).
REQ-017 SHALL register an accepted write into rf_wren/rf_waddr/rf_wdata at the accepting edge: one-cycle latency, so the register file captures it at the following edge.
REQ-018 SHALL drive rf_wren=0 in any cycle following an edge with no accepted transfer; rf_waddr/rf_wdata SHALL then hold their previous values.
REQ-019 SHALL sustain one accepted write per cycle, with no bubble between back-to-back grants.
REQ-020 SHALL set pending[a] at the edge accepting a write to a, and clear it at the next edge unless a new write to a is accepted at that edge; set wins over clear.
REQ-021 SHALL require that a requester with valid=1 and ready=0 keeps addr/data stable; the arbiter SHALL NOT buffer losing requests.
REQ-022 SHALL forward writes to any address, including 0, unchanged; address filtering is not performed.

Reset
REQ-023 SHALL, when rst_n=0 at an edge, set rf_wren=0, rf_waddr=0, rf_wdata=0, pending=0, last_grant=G1.
REQ-024 SHALL discard a write held in the output register when reset arrives mid-operation; it SHALL never reach rf_wren.
REQ-025 SHALL hold req0_ready=req1_ready=0 throughout any cycle with rst_n=0.

Configuration
REQ-026 SHALL use macro RF_WB_ROUND_ROBIN_EN.
REQ-027 SHALL, with RF_WB_ROUND_ROBIN_EN defined, grant on contention to the requester not recorded in last_grant.
REQ-028 SHALL, with RF_WB_ROUND_ROBIN_EN undefined, always grant requester 0 on contention; last_grant SHALL still be kept but SHALL not influence arbitration.

Structure
REQ-029 SHALL place AW/DW defaults and the G0/G1 grant encoding in shared package rf_pkg.
REQ-030 SHALL implement the pending bitmap as sub-module rf_pending_tracker (inputs: set_en, set_addr, clr_en, clr_addr; output: pending).

Verification
REQ-031 SHALL cover: req0 only, addr=3 data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle rf_wren=1, rf_waddr=3, rf_wdata=0xDEADBEEF, pending[3]=1; cycle after, pending[3]=0.
REQ-032 SHALL cover: both valid for 4 cycles with round robin enabled from reset -> grants 0,1,0,1; with macro off -> 0,0,0,0 while req1 stays stalled.
REQ-033 SHALL cover: hold=1 with both valid -> both ready=0; following cycle rf_wren=0; release -> grant resumes per policy.
REQ-034 SHALL cover: back-to-back writes to addr 7 on consecutive cycles -> pending[7] stays 1 without a gap, cleared one cycle after the last commit.
REQ-035 SHALL cover: rst_n=0 in the cycle after acceptance of a write to addr 9 -> rf_wren stays 0, pending=0, no write to 9.
REQ-036 SHALL cover: write to addr 0 data=5 -> rf_wren=1, rf_waddr=0, rf_wdata=5, i.e. forwarded.
